// File: rtl/arb_ram_if.sv
// arb_ram_if: request/grant bus bundle for the arbitrated RAM.
// One slice per requester port in every vector.
interface arb_ram_if #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32
);
    logic [NUM_PORTS-1:0]          req_i;
    logic [NUM_PORTS-1:0]          we_i;
    logic [NUM_PORTS*DATA_W/8-1:0] sel_i;
    logic [NUM_PORTS*ADDR_W-1:0]   addr_i;
    logic [NUM_PORTS*DATA_W-1:0]   data_i;
    logic [NUM_PORTS-1:0]          gnt_o;
    logic [NUM_PORTS-1:0]          rvalid_o;
    logic [NUM_PORTS*DATA_W-1:0]   data_o;

    modport master (
        output req_i, we_i, sel_i, addr_i, data_i,
        input  gnt_o, rvalid_o, data_o
    );

    modport slave (
        input  req_i, we_i, sel_i, addr_i, data_i,
        output gnt_o, rvalid_o, data_o
    );
endinterface

// File: rtl/arb_ram.sv
// arb_ram: single-bank RAM shared by NUM_PORTS requesters, one access per cycle.
// Define RAM_RR_ARB_EN for round-robin arbitration; default is fixed priority.
module arb_ram #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4096,
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32
) (
    input  logic     clk_i,
    input  logic     n_rst_i,
    arb_ram_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFS_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic                        found;
    logic                        any_gnt;
    logic [PW-1:0]               gidx;
    logic [NUM_PORTS-1:0]        gnt;
    logic                        g_we;
    logic [NB-1:0]               g_sel;
    logic [ADDR_W-1:0]           g_addr;
    logic [DATA_W-1:0]           g_data;
    logic [IDX_W-1:0]            g_idx;
    logic                        unused_addr;
    logic [NUM_PORTS-1:0]        rvalid_q;
    logic [NUM_PORTS*DATA_W-1:0] rdata_q;

`ifdef RAM_RR_ARB_EN
    logic [PW-1:0] ptr_q;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        int cand;
        found = 1'b0;
        gidx  = '0;
        cand  = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = (int'(ptr_q) + i) % NUM_PORTS;
            if (!found && bus.req_i[cand]) begin
                found = 1'b1;
                gidx  = PW'(cand);
            end
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            ptr_q <= PW'(NUM_PORTS - 1);
        end else if (any_gnt) begin
            ptr_q <= gidx;
        end
    end
`else
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (bus.req_i[i]) begin
                found = 1'b1;
                gidx  = PW'(i);
            end
        end
    end
`endif

    assign any_gnt = found & n_rst_i;
    assign gnt     = any_gnt ? (NUM_PORTS'(1) << gidx) : '0;

    assign g_we   = bus.we_i[gidx];
    assign g_sel  = bus.sel_i[int'(gidx)*NB +: NB];
    assign g_addr = bus.addr_i[int'(gidx)*ADDR_W +: ADDR_W];
    assign g_data = bus.data_i[int'(gidx)*DATA_W +: DATA_W];

    // Byte offset and upper bits drop out; accesses wrap modulo DEPTH.
    assign g_idx       = g_addr[OFS_W +: IDX_W];
    assign unused_addr = ^g_addr;

    always_ff @(posedge clk_i) begin
        if (any_gnt && g_we) begin
            for (int b = 0; b < NB; b++) begin
                if (g_sel[b]) begin
                    mem[g_idx][b*8 +: 8] <= g_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= '0;
            if (any_gnt && !g_we) begin
                rvalid_q[gidx]                        <= 1'b1;
                rdata_q[int'(gidx)*DATA_W +: DATA_W] <= mem[g_idx];
            end
        end
    end

    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rvalid_q;
    assign bus.data_o   = rdata_q;
endmodule
